// File: rtl/pmem_rr_arbiter.sv
// Shares one physical-memory port between icache and dcache.
// Dcache has priority, bounded by a starvation counter.
module pmem_rr_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 16,
  parameter int BLOCK_W      = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               icache_pmem_read,
  input  logic [ADDR_W-1:0]  icache_pmem_address,
  output logic               icache_pmem_resp,
  output logic [BLOCK_W-1:0] icache_pmem_rdata,
  input  logic               dcache_pmem_read,
  input  logic               dcache_pmem_write,
  input  logic [ADDR_W-1:0]  dcache_pmem_address,
  input  logic [BLOCK_W-1:0] dcache_pmem_wdata,
  output logic               dcache_pmem_resp,
  output logic [BLOCK_W-1:0] dcache_pmem_rdata,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [ADDR_W-1:0]  pmem_address,
  output logic [BLOCK_W-1:0] pmem_wdata,
  input  logic [BLOCK_W-1:0] pmem_rdata,
  input  logic               pmem_resp,
  output logic               ld_regs
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    RELEASE
  } state_t;

  state_t             state;
  logic               cmd_rd;
  logic               cmd_wr;
  logic [ADDR_W-1:0]  addr_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic [SW-1:0]      d_streak;

  logic i_req;
  logic d_req;
  logic busy;
  logic grant_i;

  always_comb begin
    i_req   = icache_pmem_read;
    d_req   = dcache_pmem_read | dcache_pmem_write;
    busy    = (state == I_BUSY) | (state == D_BUSY);
    grant_i = i_req & (~d_req | (d_streak == LIMIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cmd_rd   <= 1'b0;
      cmd_wr   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      d_streak <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_i) begin
            state    <= I_BUSY;
            addr_q   <= icache_pmem_address;
            wdata_q  <= '0;
            cmd_rd   <= 1'b1;
            cmd_wr   <= 1'b0;
            d_streak <= '0;
          end else if (d_req) begin
            state   <= D_BUSY;
            addr_q  <= dcache_pmem_address;
            wdata_q <= dcache_pmem_wdata;
            // a write-back wins over a simultaneous line fill
            cmd_wr  <= dcache_pmem_write;
            cmd_rd  <= ~dcache_pmem_write;
            if (!i_req)
              d_streak <= '0;
            else if (d_streak != LIMIT)
              d_streak <= d_streak + SW'(1);
          end
        end
        I_BUSY, D_BUSY: begin
          if (pmem_resp)
            state <= RELEASE;
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pmem_read         = busy & cmd_rd;
    pmem_write        = busy & cmd_wr;
    pmem_address      = addr_q;
    pmem_wdata        = wdata_q;
    icache_pmem_resp  = (state == I_BUSY) & pmem_resp;
    dcache_pmem_resp  = (state == D_BUSY) & pmem_resp;
    icache_pmem_rdata = pmem_rdata;
    dcache_pmem_rdata = pmem_rdata;
    ld_regs           = (state == IDLE) & ~i_req & ~d_req;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_one_resp: assert (!(icache_pmem_resp && dcache_pmem_resp));
      a_one_cmd:  assert (!(pmem_read && pmem_write));
    end
  end

endmodule

// File: tb/tb_pmem_rr_arbiter.sv
// Directed bench for pmem_rr_arbiter.
// Inputs change 1ns after posedge; outputs are checked at negedge.
module tb_pmem_rr_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic         icache_pmem_resp;
  logic [127:0] icache_pmem_rdata;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic         dcache_pmem_resp;
  logic [127:0] dcache_pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         ld_regs;

  int passed = 0;
  int total  = 0;

  localparam logic [15:0]  I_ADDR = 16'h1000;
  localparam logic [15:0]  D_ADDR = 16'h2000;
  localparam logic [127:0] WB =
    128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] RD =
    128'hCAFE_F00D_0123_4567_89AB_CDEF_0F0F_A5A5;

  pmem_rr_arbiter #(
    .STARVE_LIMIT(4),
    .ADDR_W(16),
    .BLOCK_W(128)
  ) dut (
    .clk(clk),
    .reset(reset),
    .icache_pmem_read(icache_pmem_read),
    .icache_pmem_address(icache_pmem_address),
    .icache_pmem_resp(icache_pmem_resp),
    .icache_pmem_rdata(icache_pmem_rdata),
    .dcache_pmem_read(dcache_pmem_read),
    .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address),
    .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_resp(dcache_pmem_resp),
    .dcache_pmem_rdata(dcache_pmem_rdata),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp),
    .ld_regs(ld_regs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait for a grant, respond one cycle later, report the address served
  task automatic serve(output logic [15:0] a);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pmem_read | pmem_write) seen = 1'b1;
    end
    chk("serve_grant_seen", {127'b0, seen}, 128'd1);
    a = pmem_address;
    step();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
  endtask

  initial begin
    logic [15:0] got;
    reset               = 1'b1;
    icache_pmem_read    = 1'b0;
    icache_pmem_address = '0;
    dcache_pmem_read    = 1'b0;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = '0;
    dcache_pmem_wdata   = '0;
    pmem_rdata          = '0;
    pmem_resp           = 1'b0;
    step();
    step();
    reset = 1'b0;

    // idle after reset
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_ctl",
          {123'b0, pmem_read, pmem_write, icache_pmem_resp,
           dcache_pmem_resp, ld_regs}, 128'd1);
      chk("idle_addr_data", {pmem_address, pmem_wdata[111:0]}, '0);
    end

    // icache read, response on third busy cycle
    step();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1230;
    @(negedge clk);
    chk("i_c0_ldregs", {127'b0, ld_regs}, 128'd0);
    chk("i_c0_read", {127'b0, pmem_read}, 128'd0);
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin
        pmem_resp  = 1'b1;
        pmem_rdata = RD;
      end
      @(negedge clk);
      chk("i_busy_cmd", {126'b0, pmem_read, pmem_write}, 128'd2);
      chk("i_busy_addr", {112'b0, pmem_address}, 128'h1230);
      chk("i_busy_resp", {126'b0, icache_pmem_resp, dcache_pmem_resp},
          (c == 3) ? 128'd2 : 128'd0);
      chk("i_busy_ldregs", {127'b0, ld_regs}, 128'd0);
    end
    chk("rdata_to_icache", icache_pmem_rdata, RD);
    chk("rdata_to_dcache", dcache_pmem_rdata, RD);
    step();
    pmem_resp        = 1'b0;
    icache_pmem_read = 1'b0;
    @(negedge clk);
    chk("i_release",
        {124'b0, pmem_read, pmem_write, icache_pmem_resp, ld_regs},
        128'd0);
    step();
    @(negedge clk);
    chk("i_back_idle_ldregs", {127'b0, ld_regs}, 128'd1);

    // dcache write-back, read also raised: write wins
    dcache_pmem_read    = 1'b1;
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h4440;
    dcache_pmem_wdata   = WB;
    for (int c = 1; c <= 2; c++) begin
      step();
      if (c == 2) pmem_resp = 1'b1;
      @(negedge clk);
      chk("d_wb_cmd", {126'b0, pmem_read, pmem_write}, 128'd1);
      chk("d_wb_addr", {112'b0, pmem_address}, 128'h4440);
      chk("d_wb_data", pmem_wdata, WB);
      chk("d_wb_resp", {126'b0, icache_pmem_resp, dcache_pmem_resp},
          (c == 2) ? 128'd1 : 128'd0);
    end
    step();
    pmem_resp         = 1'b0;
    dcache_pmem_read  = 1'b0;
    dcache_pmem_write = 1'b0;
    @(negedge clk);
    chk("d_wb_release",
        {125'b0, pmem_read, pmem_write, dcache_pmem_resp}, 128'd0);
    step();

    // dcache read dropped mid-transaction, resp delayed
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h5550;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2) dcache_pmem_read = 1'b0;
      if (c == 6) pmem_resp = 1'b1;
      @(negedge clk);
      chk("drop_cmd", {126'b0, pmem_read, pmem_write}, 128'd2);
      chk("drop_addr", {112'b0, pmem_address}, 128'h5550);
      chk("drop_resp", {127'b0, dcache_pmem_resp},
          (c == 6) ? 128'd1 : 128'd0);
    end
    step();
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("drop_release", {126'b0, pmem_read, ld_regs}, 128'd0);
    step();
    @(negedge clk);
    chk("drop_idle_ldregs", {127'b0, ld_regs}, 128'd1);

    // both requesting: D,D,D,D,I repeated
    icache_pmem_read    = 1'b1;
    icache_pmem_address = I_ADDR;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = D_ADDR;
    for (int k = 0; k < 10; k++) begin
      serve(got);
      chk("fair_order", {112'b0, got},
          {112'b0, (k % 5 == 4) ? I_ADDR : D_ADDR});
    end

    // build a streak of 3, then reset during the third D_BUSY
    serve(got);
    serve(got);
    for (int i = 0; i < 20 && !pmem_read; i++) @(negedge clk);
    chk("rst_in_dbusy", {112'b0, pmem_address}, {112'b0, D_ADDR});
    step();
    reset            = 1'b1;
    icache_pmem_read = 1'b0;
    dcache_pmem_read = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs",
        {pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp,
         pmem_address, pmem_wdata[107:0]}, '0);
    chk("rst_ldregs", {127'b0, ld_regs}, 128'd1);
    step();
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("late_resp_blocked",
        {126'b0, icache_pmem_resp, dcache_pmem_resp}, 128'd0);
    step();
    pmem_resp        = 1'b0;
    icache_pmem_read = 1'b1;
    dcache_pmem_read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      serve(got);
      chk("post_rst_order", {112'b0, got},
          {112'b0, (k == 4) ? I_ADDR : D_ADDR});
    end

    icache_pmem_read = 1'b0;
    dcache_pmem_read = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
